// File: rtl/counter_pkg.sv
// Shared constants and helpers for the event/cycle counter.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int max_count_of(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/counter_4bit_tc_detect.sv
// Terminal-count detect for counter_4bit.
// Wrap mode gates the compare with enable; saturate mode does not.
module counter_tc_detect
  import counter_pkg::*;
#(
  parameter int              WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count_of(WIDTH)),
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             tc
);

  logic at_max;

  assign at_max = (count == MAX_COUNT);

  always_comb begin
    tc = 1'b0;
    if (!clear) begin
      if (SATURATE) tc = at_max;
      else          tc = enable & at_max;
    end
  end

endmodule

// File: rtl/counter_4bit.sv
// Up-counter with enable, sync reset and terminal-count flag.
// Define COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping.
module counter_4bit
  import counter_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count_of(WIDTH))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc
);

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      if (count_q == MAX_COUNT)
        count_d = SATURATE ? MAX_COUNT : '0;
      else
        count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign counter_out = count_q;

  counter_tc_detect #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_tc (
    .clear  (reset),
    .enable (enable),
    .count  (count_q),
    .tc     (tc)
  );

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed plan then random steps
// against an arithmetic reference model.
module tb_counter_4bit;

  localparam int MAX = 15;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] counter_out;
  logic       tc;

  int compared   = 0;
  int mismatched = 0;
  int model      = 0;

  counter_4bit dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out),
    .tc          (tc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check tc before the edge, count after it.
  task automatic step(input bit r, input bit e);
    logic exp_tc;
    @(negedge clock);
    reset  = r;
    enable = e;
    #1;
    exp_tc = !r && (model == MAX) && (SAT || e);
    chk("tc_pre", {31'd0, tc}, {31'd0, exp_tc});
    @(posedge clock);
    if (r)
      model = 0;
    else if (e)
      model = SAT ? ((model + 1 > MAX) ? MAX : model + 1)
                  : (model + 1) % (MAX + 1);
    #1;
    chk("count", {28'd0, counter_out}, model);
  endtask

  initial begin
    step(1, 0);
    chk("reset_zero", {28'd0, counter_out}, 0);
    chk("reset_tc", {31'd0, tc}, 0);

    repeat (3) step(0, 0);
    chk("idle_hold", {28'd0, counter_out}, 0);

    repeat (10) step(0, 1);
    chk("ten", {28'd0, counter_out}, 10);

    repeat (5) step(0, 1);
    chk("fifteen", {28'd0, counter_out}, 15);
    chk("tc_at_max", {31'd0, tc}, 1);

    step(0, 1);
    chk("wrap_or_sat", {28'd0, counter_out}, SAT ? 15 : 0);
    chk("tc_after", {31'd0, tc}, SAT ? 1 : 0);

    step(1, 0);
    repeat (7) step(0, 1);
    repeat (4) step(0, 0);
    chk("hold_seven", {28'd0, counter_out}, 7);
    chk("tc_disabled", {31'd0, tc}, 0);
    step(0, 1);
    chk("eight", {28'd0, counter_out}, 8);

    step(0, 1);
    chk("nine", {28'd0, counter_out}, 9);
    step(1, 1);
    chk("reset_prio", {28'd0, counter_out}, 0);
    chk("tc_in_reset", {31'd0, tc}, 0);
    step(0, 1);
    chk("after_reset", {28'd0, counter_out}, 1);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 24) == 0), $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
